// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receiver: FSM state encoding and default widths.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int W_DEF  = 3;
  localparam int CW_DEF = 8;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin
  import gray_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] binary
);

  // Running XOR from the MSB downwards
  always_comb begin
    logic acc;
    acc    = 1'b0;
    binary = {W{1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      acc       = acc ^ gray[i];
      binary[i] = acc;
    end
  end

endmodule

// File: rtl/gray_rx.sv
// Gray-code receiver: decodes an up-counting Gray source, checks each accepted step
// against the previous reference, flags illegal transitions and counts wraps.
module gray_rx
  import gray_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [W-1:0]  gray,
  input  logic          clear,
  output logic [W-1:0]  binary,
  output logic          overflow,
  output logic [CW-1:0] wrap_count,
  output logic          error,
  output logic          locked
);

  state_t        state_r, state_s;
  logic [W-1:0]  dec_s;
  logic [W-1:0]  ref_r, ref_s;
  logic [W-1:0]  bin_s;
  logic          ovf_s;
  logic [CW-1:0] wc_s;
  logic          err_s;

  gray2bin #(.W(W)) u_dec (
    .gray   (gray),
    .binary (dec_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: clear dominates, otherwise only En=1 samples move the FSM
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = ST_IDLE;
    end else if (en) begin
      case (state_r)
        ST_IDLE:  state_s = ST_TRACK;
        ST_TRACK: begin
          if ((dec_s == ref_r) || (dec_s == ref_r + {{(W-1){1'b0}}, 1'b1})) begin
            state_s = ST_TRACK;
          end else begin
            state_s = ST_FAULT;
          end
        end
        ST_FAULT: state_s = ST_FAULT;
        default:  state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output/datapath next values; a wrap is a legal step taken from the all-ones reference
  always_comb begin
    ref_s = ref_r;
    bin_s = binary;
    ovf_s = 1'b0;
    wc_s  = wrap_count;
    err_s = error;
    if (clear) begin
      wc_s  = {CW{1'b0}};
      err_s = 1'b0;
    end else if (en) begin
      bin_s = dec_s;
      case (state_r)
        ST_IDLE:  ref_s = dec_s;
        ST_TRACK: begin
          if (dec_s == ref_r) begin
            ref_s = ref_r;
          end else if (dec_s == ref_r + {{(W-1){1'b0}}, 1'b1}) begin
            ref_s = dec_s;
            if (&ref_r) begin
              ovf_s = 1'b1;
              if (!(&wrap_count)) begin
                wc_s = wrap_count + {{(CW-1){1'b0}}, 1'b1};
              end else begin
                wc_s = wrap_count;
              end
            end else begin
              ovf_s = 1'b0;
            end
          end else begin
            err_s = 1'b1;
          end
        end
        ST_FAULT: ref_s = ref_r;
        default:  ref_s = ref_r;
      endcase
    end else begin
      bin_s = binary;
    end
  end

  // Registered outputs and reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_r      <= {W{1'b0}};
      binary     <= {W{1'b0}};
      overflow   <= 1'b0;
      wrap_count <= {CW{1'b0}};
      error      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      ref_r      <= ref_s;
      binary     <= bin_s;
      overflow   <= ovf_s;
      wrap_count <= wc_s;
      error      <= err_s;
      locked     <= (state_s == ST_TRACK);
    end
  end

endmodule

// File: doc/gray_rx.md
GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 Parameter W, default 3, Gray code width in bits (W >= 2).
REQ-002 Parameter CW, default 8, width of the wrap counter.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 En  input  1  sample strobe; Gray is consumed only in cycles with En=1.
REQ-006 Gray  input  W  Gray-coded count from an up-counting Gray source.
REQ-007 Clear  input  1  synchronous clear of the fault and wrap state.
REQ-008 Binary  output  W  registered binary decode of the last accepted sample.
REQ-009 Overflow  output  1  one-cycle pulse when an accepted step wraps from 2^W-1 to 0.
REQ-010 WrapCount  output  CW  saturating count of Overflow pulses.
REQ-011 Error  output  1  sticky flag for an illegal transition.
REQ-012 Locked  output  1  high while in TRACK.

Function
REQ-013 The FSM SHALL have three states: IDLE (no reference sample), TRACK and FAULT.
REQ-014 Decode SHALL be b[W-1]=g[W-1] and b[i]=b[i+1]^g[i]; Binary SHALL update one cycle after each En=1 sample, in every state.
REQ-015 IDLE with En=1 SHALL store the decoded sample as the reference and go to TRACK, with no check, no Overflow and no Error.
REQ-016 In TRACK with En=1, a sample equal to the reference SHALL be a legal hold: state unchanged, no pulse.
REQ-017 In TRACK with En=1, a sample whose decode equals (reference+1) mod 2^W SHALL be a legal step: the reference updates and the state stays TRACK.
REQ-018 A legal step from 2^W-1 to 0 SHALL assert Overflow for exactly the cycle in which Binary shows 0, and SHALL increment WrapCount in the same cycle.
REQ-019 WrapCount SHALL saturate at 2^CW-1; Overflow still pulses at saturation.
REQ-020 In TRACK with En=1, any other sample (down-step, skip, or multi-bit change) SHALL be illegal: Error=1 from the next cycle, state goes to FAULT, no Overflow, WrapCount unchanged.
REQ-021 FAULT SHALL keep decoding Binary but SHALL perform no checking, generate no Overflow and leave WrapCount frozen.
REQ-022 Clear=1 SHALL, from any state, set Error=0 and WrapCount=0, go to IDLE, and discard any simultaneous En sample.
REQ-023 With En=0, Binary, WrapCount, Error and the state SHALL hold, and Overflow SHALL be 0.
REQ-024 Locked SHALL equal (state==TRACK), registered.

Reset
REQ-025 Reset low SHALL immediately force IDLE, Binary=0, Overflow=0, WrapCount=0, Error=0 and Locked=0, regardless of Clk.
REQ-026 Reset asserted mid-stream SHALL discard the reference; the first En sample after release re-enters TRACK without any check.
REQ-027 Reset deassertion SHALL take effect on the first rising Clk edge after release.

Structure
REQ-028 Package gray_pkg SHALL hold the state encoding (IDLE/TRACK/FAULT) and the default W and CW constants.
REQ-029 Sub-module gray2bin SHALL be a combinational, W-parameterised decoder instantiated once; all registers SHALL live in gray_rx.

Verification
REQ-030 Scenario 1 (W=3): Reset, then En=1 with Gray 000,001,011,010,110,111,101,100,000 -> Binary 0..7,0; one Overflow pulse on the final 0; WrapCount=1; Error=0.
REQ-031 Scenario 2: TRACK at Gray 011, then Gray 001 -> Error=1 next cycle, Locked=0, Overflow=0, WrapCount unchanged; further legal steps leave Error=1.
REQ-032 Scenario 3: TRACK at Gray 000, then Gray 011 (multi-bit) -> FAULT; then Clear=1 with En=1, Gray 010 -> IDLE, Error=0, WrapCount=0; next sample 010 accepted as reference without error.
REQ-033 Scenario 4: first sample after reset is Gray 101 -> Binary=6, Locked=1, no Error; the same value repeated 5 times -> no change, no pulse.
REQ-034 Scenario 5: CW=2; drive 4 full wraps -> WrapCount=3 (saturated) and Overflow pulses 4 times.
REQ-035 Scenario 6: Reset pulsed low mid-cycle between samples -> all outputs 0 asynchronously; the next sample Gray 110 is accepted as the reference with Binary=4.
